// File: rtl/irq_sched.sv
// irq_sched - interrupt scheduler sitting between the device IRQ lines and CP0.
//
// Captures up to N_SRC device interrupt lines into a pending register, each in
// level or rising-edge mode, masks them, and presents one selected source at a
// time to the CPU through a request / acknowledge / end-of-interrupt handshake.
// A four-word register file on the peripheral bus gives software access.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   irq_in   device IRQ lines (bit 0 = timer0, bit 1 = timer1)
//   addr     word select [3:2]: 00 MASK, 01 PEND, 10 CUR, 11 CFG
//   WE       register write enable
//   din      write data
//   ack      CPU took the interrupt (one-cycle pulse)
//   dataOut  read data, combinational on addr
//   hw_int   pend & mask, routed to CP0 HWInt[7:2]
//   irq_req  scheduled request to the CPU
//   cur_id   source currently requested or in service
//
// Build option: define IRQ_SCHED_RR_EN for round-robin arbitration (CUR[6:4]
// then reads the last serviced id); otherwise fixed lowest-index priority.

module irq_sched #(
    parameter int N_SRC = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  irq_in,
    input  logic [3:2]  addr,
    input  logic        WE,
    input  logic [31:0] din,
    input  logic        ack,
    output logic [31:0] dataOut,
    output logic [5:0]  hw_int,
    output logic        irq_req,
    output logic [2:0]  cur_id
);

    localparam logic [5:0] SRC_MASK = 6'((1 << N_SRC) - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SERV = 2'd2;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_PEND = 2'd1;
    localparam logic [1:0] A_CUR  = 2'd2;
    localparam logic [1:0] A_CFG  = 2'd3;

    logic [5:0] mask_q, mask_d;
    logic [5:0] pend_q, pend_d;
    logic [5:0] cfg_q, cfg_d;
    logic [5:0] prev_q, prev_d;
    logic [1:0] state_q, state_d;
    logic [2:0] cur_id_q, cur_id_d;
    logic [2:0] last_q, last_d;

    logic       wr_mask, wr_pend, wr_cur, wr_cfg, eoi;
    logic [5:0] set_vec, clr_vec, req_vec;
    logic [2:0] winner;
    logic       found;
    logic [31:0] cur_word;
    logic       unused_din;

    assign unused_din = ^din[31:6];

    // Bus decode; an end-of-interrupt only counts while a source is in service.
    always_comb begin
        wr_mask = WE && (addr == A_MASK);
        wr_pend = WE && (addr == A_PEND);
        wr_cur  = WE && (addr == A_CUR);
        wr_cfg  = WE && (addr == A_CFG);
        eoi     = wr_cur && (state_q == ST_SERV);
    end

    // Pending capture: level sources set while high, edge sources on a 0->1
    // step against last cycle's line. Set is applied after clear so a fresh
    // event is never lost to a simultaneous software clear or EOI.
    always_comb begin
        set_vec = ((irq_in & ~cfg_q) | (irq_in & ~prev_q & cfg_q)) & SRC_MASK;
        clr_vec = 6'b0;
        if (wr_pend) begin
            clr_vec = clr_vec | din[5:0];
        end
        if (eoi) begin
            clr_vec = clr_vec | (6'b1 << cur_id_q);
        end
        pend_d = ((pend_q & ~clr_vec) | set_vec) & SRC_MASK;
        prev_d = irq_in & SRC_MASK;
        mask_d = wr_mask ? (din[5:0] & SRC_MASK) : mask_q;
        cfg_d  = wr_cfg  ? (din[5:0] & SRC_MASK) : cfg_q;
        last_d = eoi ? cur_id_q : last_q;
    end

    // Arbitration over the currently pending-and-enabled sources.
    always_comb begin
        req_vec = pend_q & mask_q;
        winner  = 3'd0;
        found   = 1'b0;
`ifdef IRQ_SCHED_RR_EN
        for (int k = 0; k < N_SRC; k++) begin
            if (!found && req_vec[(int'(last_q) + 1 + k) % N_SRC]) begin
                winner = 3'((int'(last_q) + 1 + k) % N_SRC);
                found  = 1'b1;
            end
        end
`else
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                winner = 3'(i);
                found  = 1'b1;
            end
        end
`endif
    end

    // Handshake FSM. In REQ the withdrawal test looks at next-cycle mask and
    // pending so a software clear retracts the request on the same edge, while
    // a simultaneous ack still takes priority.
    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    cur_id_d = winner;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_d = ST_SERV;
                end else if (!mask_d[cur_id_q] || !pend_d[cur_id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERV: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q   <= 6'b0;
            pend_q   <= 6'b0;
            cfg_q    <= 6'b0;
            prev_q   <= 6'b0;
            state_q  <= ST_IDLE;
            cur_id_q <= 3'd0;
            last_q   <= 3'(N_SRC - 1);
        end else begin
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            cfg_q    <= cfg_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            last_q   <= last_d;
        end
    end

    // Read mux; the CUR word carries busy, state, last-served and current id.
    always_comb begin
        cur_word      = 32'b0;
        cur_word[31]  = (state_q != ST_IDLE);
        cur_word[9:8] = state_q;
`ifdef IRQ_SCHED_RR_EN
        cur_word[6:4] = last_q;
`endif
        cur_word[2:0] = cur_id_q;
        case (addr)
            A_MASK:  dataOut = {26'b0, mask_q};
            A_PEND:  dataOut = {26'b0, pend_q};
            A_CUR:   dataOut = cur_word;
            default: dataOut = {26'b0, cfg_q};
        endcase
    end

    assign hw_int  = pend_q & mask_q;
    assign irq_req = (state_q == ST_REQ);
    assign cur_id  = cur_id_q;

endmodule

// File: tb/tb_irq_sched.sv
// tb_irq_sched - directed self-checking bench for irq_sched.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.

module tb_irq_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  irq_in;
    logic [3:2]  addr;
    logic        WE;
    logic [31:0] din;
    logic        ack;
    logic [31:0] dataOut;
    logic [5:0]  hw_int;
    logic        irq_req;
    logic [2:0]  cur_id;

    int assertCount = 0;
    int failCount   = 0;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_PEND = 2'd1;
    localparam logic [1:0] A_CUR  = 2'd2;
    localparam logic [1:0] A_CFG  = 2'd3;

`ifdef IRQ_SCHED_RR_EN
    localparam bit RR = 1'b1;
    localparam logic [2:0] FIRST_ID  = 3'd1;
    localparam logic [2:0] SECOND_ID = 3'd0;
`else
    localparam bit RR = 1'b0;
    localparam logic [2:0] FIRST_ID  = 3'd0;
    localparam logic [2:0] SECOND_ID = 3'd1;
`endif

    irq_sched #(.N_SRC(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .addr    (addr),
        .WE      (WE),
        .din     (din),
        .ack     (ack),
        .dataOut (dataOut),
        .hw_int  (hw_int),
        .irq_req (irq_req),
        .cur_id  (cur_id)
    );

    always #5 clk = ~clk;

    // Watchdog in case the stimulus ever stalls.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected CUR word; last-served field only exists in the round-robin build.
    function automatic logic [31:0] exp_cur(input logic busy, input logic [1:0] st,
                                            input logic [2:0] ls, input logic [2:0] id);
        logic [2:0] lsf;
        lsf = RR ? ls : 3'd0;
        return {busy, 21'b0, st, 1'b0, lsf, 1'b0, id};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one bus/ack cycle across a rising edge, then return to idle inputs.
    task automatic applyStimulus(input logic we_i, input logic [1:0] a,
                                 input logic [31:0] d, input logic ack_i);
        WE   = we_i;
        addr = a;
        din  = d;
        ack  = ack_i;
        @(posedge clk);
        #1;
        WE  = 1'b0;
        ack = 1'b0;
        din = 32'b0;
    endtask

    task automatic tick();
        applyStimulus(1'b0, A_MASK, 32'b0, 1'b0);
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] data);
        addr = a;
        #1;
        data = dataOut;
    endtask

    logic [31:0] rd;

    initial begin
        reset  = 1'b1;
        irq_in = 6'b0;
        addr   = 2'b0;
        WE     = 1'b0;
        din    = 32'b0;
        ack    = 1'b0;
        @(posedge clk);
        #1;
        tick();
        reset = 1'b0;

        // Reset state
        checkOutput("rst_hw_int", 32'(hw_int), 32'h0);
        checkOutput("rst_irq_req", 32'(irq_req), 32'h0);
        checkOutput("rst_cur_id", 32'(cur_id), 32'h0);
        readReg(A_MASK, rd); checkOutput("rst_mask", rd, 32'h0);
        readReg(A_CUR, rd);  checkOutput("rst_cur", rd, exp_cur(1'b0, 2'd0, 3'd5, 3'd0));

        // Edge-mode single pulse on source 1
        applyStimulus(1'b1, A_MASK, 32'h03, 1'b0);
        applyStimulus(1'b1, A_CFG, 32'h03, 1'b0);
        irq_in = 6'h02;
        tick();
        irq_in = 6'h00;
        checkOutput("t1_hw_int", 32'(hw_int), 32'h02);
        checkOutput("t1_req_early", 32'(irq_req), 32'h0);
        tick();
        checkOutput("t1_req", 32'(irq_req), 32'h1);
        checkOutput("t1_id", 32'(cur_id), 32'h1);
        applyStimulus(1'b0, A_MASK, 32'b0, 1'b1);
        checkOutput("t1_req_after_ack", 32'(irq_req), 32'h0);
        readReg(A_CUR, rd);  checkOutput("t1_cur_serv", rd, exp_cur(1'b1, 2'd2, 3'd5, 3'd1));
        applyStimulus(1'b1, A_CUR, 32'h0, 1'b0);
        readReg(A_PEND, rd); checkOutput("t1_pend_eoi", rd, 32'h0);
        readReg(A_CUR, rd);  checkOutput("t1_cur_idle", rd, exp_cur(1'b0, 2'd0, 3'd1, 3'd1));

        // Level source masked, then unmasked
        applyStimulus(1'b1, A_CFG, 32'h00, 1'b0);
        applyStimulus(1'b1, A_MASK, 32'h00, 1'b0);
        irq_in = 6'h01;
        tick();
        readReg(A_PEND, rd); checkOutput("t2_pend", rd, 32'h01);
        checkOutput("t2_hw_int", 32'(hw_int), 32'h0);
        tick();
        checkOutput("t2_req_masked", 32'(irq_req), 32'h0);
        applyStimulus(1'b1, A_MASK, 32'h01, 1'b0);
        checkOutput("t2_req_1edge", 32'(irq_req), 32'h0);
        tick();
        checkOutput("t2_req", 32'(irq_req), 32'h1);
        checkOutput("t2_id", 32'(cur_id), 32'h0);
        irq_in = 6'h00;
        applyStimulus(1'b0, A_MASK, 32'b0, 1'b1);
        applyStimulus(1'b1, A_CUR, 32'h0, 1'b0);
        readReg(A_PEND, rd); checkOutput("t2_pend_eoi", rd, 32'h0);

        // Simultaneous edges on sources 0 and 1
        applyStimulus(1'b1, A_CFG, 32'h03, 1'b0);
        applyStimulus(1'b1, A_MASK, 32'h03, 1'b0);
        irq_in = 6'h03;
        tick();
        irq_in = 6'h00;
        readReg(A_PEND, rd); checkOutput("t3_pend", rd, 32'h03);
        tick();
        checkOutput("t3_req1", 32'(irq_req), 32'h1);
        checkOutput("t3_id1", 32'(cur_id), 32'(FIRST_ID));
        applyStimulus(1'b0, A_MASK, 32'b0, 1'b1);
        applyStimulus(1'b1, A_CUR, 32'h0, 1'b0);
        readReg(A_PEND, rd); checkOutput("t3_pend_mid", rd, 32'(6'b1 << SECOND_ID));
        tick();
        checkOutput("t3_req2", 32'(irq_req), 32'h1);
        checkOutput("t3_id2", 32'(cur_id), 32'(SECOND_ID));
        applyStimulus(1'b0, A_MASK, 32'b0, 1'b1);
        applyStimulus(1'b1, A_CUR, 32'h0, 1'b0);
        readReg(A_PEND, rd); checkOutput("t3_pend_end", rd, 32'h0);

        // Software withdraws a request in REQ, then the same with ack
        applyStimulus(1'b1, A_CFG, 32'h04, 1'b0);
        applyStimulus(1'b1, A_MASK, 32'h04, 1'b0);
        irq_in = 6'h04;
        tick();
        irq_in = 6'h00;
        tick();
        checkOutput("t4_req", 32'(irq_req), 32'h1);
        checkOutput("t4_id", 32'(cur_id), 32'h2);
        applyStimulus(1'b1, A_PEND, 32'h04, 1'b0);
        checkOutput("t4_withdrawn", 32'(irq_req), 32'h0);
        readReg(A_CUR, rd);  checkOutput("t4_cur_idle", rd, exp_cur(1'b0, 2'd0, 3'd0, 3'd2));
        tick();
        checkOutput("t4_no_rereq", 32'(irq_req), 32'h0);
        irq_in = 6'h04;
        tick();
        irq_in = 6'h00;
        tick();
        checkOutput("t4_req_again", 32'(irq_req), 32'h1);
        applyStimulus(1'b1, A_PEND, 32'h04, 1'b1);
        readReg(A_CUR, rd);  checkOutput("t4_ack_wins", rd, exp_cur(1'b1, 2'd2, 3'd0, 3'd2));
        applyStimulus(1'b1, A_CUR, 32'h0, 1'b0);
        readReg(A_CUR, rd);  checkOutput("t4_cur_eoi", rd, exp_cur(1'b0, 2'd0, 3'd2, 3'd2));

        // Level source still high at EOI: pending survives, request repeats
        applyStimulus(1'b1, A_CFG, 32'h00, 1'b0);
        applyStimulus(1'b1, A_MASK, 32'h01, 1'b0);
        irq_in = 6'h01;
        tick();
        checkOutput("t5_hw_int", 32'(hw_int), 32'h01);
        tick();
        checkOutput("t5_req", 32'(irq_req), 32'h1);
        applyStimulus(1'b1, A_CUR, 32'h0, 1'b0);
        checkOutput("t5_eoi_in_req", 32'(irq_req), 32'h1);
        applyStimulus(1'b0, A_MASK, 32'b0, 1'b1);
        readReg(A_CUR, rd);  checkOutput("t5_cur_serv", rd, exp_cur(1'b1, 2'd2, 3'd2, 3'd0));
        applyStimulus(1'b1, A_CUR, 32'h0, 1'b0);
        readReg(A_PEND, rd); checkOutput("t5_set_wins", rd, 32'h01);
        checkOutput("t5_idle", 32'(irq_req), 32'h0);
        tick();
        checkOutput("t5_rereq", 32'(irq_req), 32'h1);
        checkOutput("t5_id", 32'(cur_id), 32'h0);

        // Reset while in service with two sources pending
        applyStimulus(1'b0, A_MASK, 32'b0, 1'b1);
        irq_in = 6'h05;
        tick();
        readReg(A_PEND, rd); checkOutput("t6_pend", rd, 32'h05);
        readReg(A_CUR, rd);  checkOutput("t6_cur_serv", rd, exp_cur(1'b1, 2'd2, 3'd0, 3'd0));
        reset  = 1'b1;
        irq_in = 6'h00;
        tick();
        reset = 1'b0;
        readReg(A_MASK, rd); checkOutput("t6_mask", rd, 32'h0);
        readReg(A_PEND, rd); checkOutput("t6_pend_rst", rd, 32'h0);
        readReg(A_CFG, rd);  checkOutput("t6_cfg", rd, 32'h0);
        readReg(A_CUR, rd);  checkOutput("t6_cur", rd, exp_cur(1'b0, 2'd0, 3'd5, 3'd0));
        checkOutput("t6_irq_req", 32'(irq_req), 32'h0);
        checkOutput("t6_hw_int", 32'(hw_int), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
